// File: rtl/main_mem_responder.sv
// main_mem_responder: memory-side end of the I-cache line fill; returns a 128-bit line
// a fixed number of cycles after a request, from a side-port-loaded word array.
module main_mem_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4,
    parameter int CACHE_LINE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [31:0]           mem_addr,
    output logic [CACHE_LINE-1:0] mem_data_out,
    output logic                  mem_ready,
    input  logic                  init_we,
    input  logic [31:0]           init_addr,
    input  logic [31:0]           init_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_mem [MEM_WORDS];
    logic [AW-1:0]         r_base;
    logic [CW-1:0]         r_cnt;
    logic [CACHE_LINE-1:0] r_line;
    logic                  w_unused;

    assign w_unused = ^{mem_addr[31:AW+2], mem_addr[1:0], init_addr[31:AW+2], init_addr[1:0]};

    // Storage is never reset; the side port writes in every state.
    always_ff @(posedge clk)
        if (init_we) r_mem[init_addr[AW+1:2]] <= init_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = mem_req ? WAIT : IDLE;
            WAIT:    w_next = (r_cnt == '0) ? RESP : WAIT;
            RESP:    w_next = DRAIN;
            DRAIN:   w_next = mem_req ? DRAIN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_base holds the word index of word 0 of the latched line.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_base <= '0;
            r_cnt  <= '0;
            r_line <= '0;
        end else if (r_state == IDLE && mem_req) begin
            r_base <= mem_addr[AW+1:2] & ~AW'(3);
            r_cnt  <= CW'(LATENCY - 1);
        end else if (r_state == WAIT) begin
            if (r_cnt != '0) r_cnt  <= r_cnt - CW'(1);
            else             r_line <= {r_mem[r_base | AW'(3)], r_mem[r_base | AW'(2)],
                                        r_mem[r_base | AW'(1)], r_mem[r_base]};
        end

    always_comb begin
        mem_ready    = (r_state == RESP);
        mem_data_out = mem_ready ? r_line : '0;
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed and random line fills on LATENCY=4 and LATENCY=1 instances
// sharing one stimulus, checked each cycle against a timing/array reference model.
module tb_main_mem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_req = 1'b0;
    logic         init_we = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  init_addr = '0;
    logic [31:0]  init_data = '0;
    logic [127:0] data4, data1;
    logic         ready4, ready1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0]  ref_mem [4096];
    bit           m_busy [2];
    bit           m_hold [2];
    bit           m_resp [2];
    int           m_due  [2];
    logic [11:0]  m_base [2];
    logic [127:0] m_cap  [2];
    int           lat    [2] = '{4, 1};

    always #5 clk = ~clk;

    main_mem_responder #(.MEM_WORDS(4096), .LATENCY(4), .CACHE_LINE(128)) dut4 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_out(data4), .mem_ready(ready4),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    main_mem_responder #(.MEM_WORDS(4096), .LATENCY(1), .CACHE_LINE(128)) dut1 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_out(data1), .mem_ready(ready1),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [11:0] b);
        return {ref_mem[b | 12'd3], ref_mem[b | 12'd2], ref_mem[b | 12'd1], ref_mem[b]};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_hold[d] = 0;
            m_resp[d] = 0;
        end
    endtask

    // Advance one clock edge: update the model from the inputs the DUT samples, then check.
    task automatic tick();
        bit nr;
        for (int d = 0; d < 2; d++) begin
            nr = 0;
            if (!rst) begin
                m_busy[d] = 0;
                m_hold[d] = 0;
            end else if (m_resp[d]) begin
                m_hold[d] = 1;
            end else if (m_hold[d]) begin
                m_hold[d] = mem_req;
            end else if (m_busy[d]) begin
                if (cyc == m_due[d]) begin
                    m_cap[d]  = line_of(m_base[d]);
                    nr        = 1;
                    m_busy[d] = 0;
                end
            end else if (mem_req) begin
                m_busy[d] = 1;
                m_base[d] = mem_addr[13:2] & 12'hFFC;
                m_due[d]  = cyc + lat[d];
            end
            m_resp[d] = nr;
        end
        if (init_we) ref_mem[init_addr[13:2]] = init_data;
        cyc++;
        @(posedge clk);
        #1;
        chk("ready_L4", ready4, m_resp[0]);
        chk("data_L4", data4, m_resp[0] ? m_cap[0] : 128'd0);
        chk("ready_L1", ready1, m_resp[1]);
        chk("data_L1", data1, m_resp[1] ? m_cap[1] : 128'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        init_we   = 1'b1;
        init_addr = a;
        init_data = v;
        tick();
        init_we   = 1'b0;
    endtask

    task automatic rtick();
        init_we   = ($urandom_range(0, 3) == 0);
        init_addr = $urandom & 32'hFFFF_C7FF;
        init_data = $urandom;
        tick();
        init_we   = 1'b0;
    endtask

    task automatic release_req();
        mem_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int hold, idle;
        model_clear();
        #2 rst = 1'b0;
        #1;
        chk("reset_ready_L4", ready4, 0);
        chk("reset_data_L4", data4, 0);
        chk("reset_ready_L1", ready1, 0);
        chk("reset_data_L1", data1, 0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 512; i++) wr(i * 4, $urandom);

        // Basic fill, then a request held past the pulse
        wr(32'h40, 32'h11111111);
        wr(32'h44, 32'h22222222);
        wr(32'h48, 32'h33333333);
        wr(32'h4C, 32'h44444444);
        mem_req  = 1'b1;
        mem_addr = 32'h48;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("basic_ready_timing", ready4, i == 4);
        end
        chk("basic_line", data4, 128'h44444444_33333333_22222222_11111111);
        repeat (3) begin
            tick();
            chk("held_no_second_ready", ready4, 0);
        end
        release_req();

        // LATENCY=1 fill of 0x100
        for (int k = 0; k < 4; k++) wr(32'h100 + k * 4, 32'hC0DE0100 + k * 4);
        mem_req  = 1'b1;
        mem_addr = 32'h100;
        tick();
        tick();
        chk("lat1_ready", ready1, 1);
        chk("lat1_line", data1, 128'hC0DE010C_C0DE0108_C0DE0104_C0DE0100);
        repeat (3) tick();
        chk("lat1_l4_ready", ready4, 1);
        release_req();

        // Wrap-around alias to line 0
        wr(32'h0, 32'h01010101);
        wr(32'h8, 32'h03030303);
        wr(32'hC, 32'h04040404);
        wr(32'h0000_0004, 32'hDEADBEEF);
        mem_req  = 1'b1;
        mem_addr = 32'h0001_0000;
        tick();
        repeat (4) tick();
        chk("wrap_word1", data4[63:32], 32'hDEADBEEF);
        chk("wrap_line", data4, 128'h04040404_03030303_DEADBEEF_01010101);
        release_req();

        // Write on the capture edge is not seen
        wr(32'h200, 32'hAAAAAAAA);
        mem_req  = 1'b1;
        mem_addr = 32'h200;
        tick();
        repeat (3) tick();
        init_we = 1'b1; init_addr = 32'h200; init_data = 32'hBBBBBBBB;
        tick();
        init_we = 1'b0;
        chk("race_same_edge", data4[31:0], 32'hAAAAAAAA);
        release_req();

        // Write one edge earlier is seen
        wr(32'h200, 32'hAAAAAAAA);
        mem_req = 1'b1;
        tick();
        repeat (2) tick();
        init_we = 1'b1; init_addr = 32'h200; init_data = 32'hBBBBBBBB;
        tick();
        init_we = 1'b0;
        tick();
        chk("race_prior_edge", data4[31:0], 32'hBBBBBBBB);
        release_req();

        // Reset in WAIT, request held through reset
        mem_req  = 1'b1;
        mem_addr = 32'h280;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        model_clear();
        chk("midrst_ready", ready4, 0);
        chk("midrst_data", data4, 0);
        tick();
        chk("midrst_held_ready", ready4, 0);
        rst = 1'b1;
        tick();
        repeat (3) begin
            tick();
            chk("rerequest_no_early_ready", ready4, 0);
        end
        tick();
        chk("rerequest_ready", ready4, 1);
        chk("rerequest_line", data4, line_of(12'h0A0));
        release_req();

        // Address change during WAIT is ignored
        for (int k = 0; k < 4; k++) wr(32'h300 + k * 4, 32'h03000000 + k * 4);
        for (int k = 0; k < 4; k++) wr(32'h400 + k * 4, 32'h04000000 + k * 4);
        mem_req  = 1'b1;
        mem_addr = 32'h300;
        tick();
        mem_addr = 32'h400;
        repeat (4) tick();
        chk("addr_change_line", data4, 128'h0300000C_03000008_03000004_03000000);
        release_req();

        // Random fills with side-port traffic, aliased addresses and early drops
        for (int t = 0; t < 200; t++) begin
            mem_addr = $urandom & 32'hFFFF_C7FF;
            mem_req  = 1'b1;
            hold     = $urandom_range(1, 8);
            rtick();
            repeat (hold) begin
                if ($urandom_range(0, 4) == 0) mem_addr = $urandom & 32'hFFFF_C7FF;
                rtick();
            end
            mem_req = 1'b0;
            idle = ((hold >= 5) ? 1 : 6 - hold) + $urandom_range(0, 1);
            repeat (idle) rtick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Memory-side end of the I-cache line-fill interface.
- Accepts a cache miss request (mem_req + mem_addr) and waits a programmable number of cycles.
- Returns the full 128-bit line with a one-cycle mem_ready pulse.
- Backed by a word-addressed storage array. The array is loaded through a side write port by the testbench or a boot loader.

Parameters:
- MEM_WORDS, 4096: storage depth in 32-bit words; power of 2, minimum 4.
- LATENCY, 4: cycles from request acceptance to response; minimum 1.
- CACHE_LINE, 128: line width in bits; fixed at 128 (4 words).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_req  input  1  line-fill request from cache; held high until mem_ready is seen.
- mem_addr  input  32  byte address of the requested word; line base = mem_addr[31:4].
- mem_data_out  output  128  returned line; word at offset k in bits [32k+31:32k].
- mem_ready  output  1  one-cycle pulse; mem_data_out is valid in that cycle.
- init_we  input  1  side-port word write enable.
- init_addr  input  32  side-port byte address; bits [1:0] ignored.
- init_data  input  32  side-port write data.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, mem_ready=0, mem_data_out=0, latency counter=0, latched line address=0.
  - Storage array contents are NOT cleared.
- Addressing:
  - Word index = addr[$clog2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo MEM_WORDS*4 bytes.
  - Line word k (k=0..3) = array[{line_index, k[1:0]}], where line_index is the latched mem_addr[$clog2(MEM_WORDS)+1:4].
- State machine:
  - IDLE: mem_ready=0, mem_data_out=0.
    - mem_req sampled high at edge N: latch line index from mem_addr, load counter=LATENCY-1, go to WAIT.
  - WAIT: mem_ready=0, mem_data_out=0.
    - counter!=0: decrement.
    - counter==0: read all 4 words from the array into the output register and go to RESP.
    - Changes to mem_addr during WAIT are ignored.
  - RESP: lasts exactly one cycle.
    - mem_ready=1 and mem_data_out=captured line.
    - Next edge: go to DRAIN.
  - DRAIN: mem_ready=0, mem_data_out=0.
    - Stay while mem_req is high.
    - Go to IDLE on the first edge where mem_req is sampled low.
    - A new request requires mem_req low for at least one cycle between requests.
- Latency:
  - Request accepted at edge N; mem_ready is high in the cycle following edge N+LATENCY.
  - LATENCY=1 gives mem_ready in the cycle after edge N+1.
- Outputs are registered; there is no combinational path from mem_req/mem_addr to mem_ready/mem_data_out.
- Side write port:
  - init_we high at an edge writes init_data to array[word index of init_addr], in any state.
  - A write on the same edge as the WAIT-to-RESP capture is not visible in that response (read-before-write).
  - Writes on any earlier edge are visible.
- mem_req dropping during WAIT: the fill still completes. RESP pulses, then DRAIN exits to IDLE on the next edge because mem_req is low.
- Reset mid-operation (any state): immediate return to IDLE with outputs zero. The pending request is discarded. A request still held high after reset is accepted as new on the first edge after rst rises.
- mem_req high in IDLE on the first clock edge after reset release is accepted normally.

Test Plan:
- Basic fill, LATENCY=4:
  - Preload words 0x40..0x4C with 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Raise mem_req with mem_addr=0x48 at edge N.
  - Required: mem_ready high only in the cycle after edge N+4, with mem_data_out=0x44444444_33333333_22222222_11111111. mem_data_out=0 in all other cycles.
- Held request:
  - Keep mem_req high 3 cycles past mem_ready.
  - Required: no second mem_ready. Drop mem_req, wait one cycle, issue a request for 0x100 with LATENCY=1; mem_ready follows 1 edge after acceptance with the line at words 0x100..0x10C.
- Wrap-around, MEM_WORDS=4096:
  - Write 0xDEADBEEF via init_addr=0x0000_0004.
  - Request mem_addr=0x0001_0000.
  - Required: mem_data_out[63:32]=0xDEADBEEF, because the address aliases to line 0.
- Write/capture race:
  - Word 0x200 = 0xAAAAAAAA. Request 0x200.
  - Write 0xBBBBBBBB to 0x200 on the capture edge: response word0=0xAAAAAAAA.
  - Repeat with the write one edge earlier: response word0=0xBBBBBBBB.
- Reset mid-WAIT:
  - Assert rst low 2 cycles after acceptance.
  - Required: mem_ready=0 and mem_data_out=0 immediately. No pulse appears.
  - Re-request after rst rises: full LATENCY measured from the new acceptance.
- Address change during WAIT:
  - Request 0x300, then switch mem_addr to 0x400 one cycle later.
  - Required: the response returns line 0x300's contents.
